// File: rtl/ble6_lut6_cfg.sv
// BLE6 programmable K-input LUT with its word-serial configuration chain loader.
// A 2**LUT_K-entry truth table plus an output-select bit are shifted in LSB-first.
module ble6_lut6_cfg #(
    parameter int unsigned LUT_K = 6,
    parameter int unsigned CFG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             cfg_done,
    input  logic [LUT_K-1:0] lut_in,
    output logic             lut_out,
    input  logic             ff_q,
    output logic             ble_out,
    output logic             ccff_tail
);

    localparam int unsigned TT_LEN    = 2 ** LUT_K;
    localparam int unsigned CHAIN_LEN = TT_LEN + 1;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned NW        = $clog2(CFG_W + 1);

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CFG_W_C     = CNT_W'(CFG_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t               state, state_nx;
    logic [CHAIN_LEN-1:0] mem, mem_nx;
    logic [CNT_W-1:0]     count, count_nx;
    logic [CFG_W-1:0]     hold, hold_nx;
    logic [NW-1:0]        remain, remain_nx;

    logic [CNT_W-1:0]     left_in_chain;
    logic [NW-1:0]        word_bits;
    logic [TT_LEN-1:0]    truth_table;
    logic                 out_sel;

    // Only the bits still missing from the chain are shifted; the tail of the last word is dropped.
    always_comb begin
        left_in_chain = CHAIN_LEN_C - count;
        word_bits     = (left_in_chain > CFG_W_C) ? NW'(CFG_W) : NW'(left_in_chain);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mem    <= '0;
            count  <= '0;
            hold   <= '0;
            remain <= '0;
        end else begin
            state  <= state_nx;
            mem    <= mem_nx;
            count  <= count_nx;
            hold   <= hold_nx;
            remain <= remain_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_nx    = mem;
        count_nx  = count;
        hold_nx   = hold;
        remain_nx = remain;
        cfg_ready = (state == LOAD);
        cfg_done  = (state == DONE);

        // A restart wins over any handshake or shift in the same cycle; chain contents are kept.
        if (cfg_start) begin
            state_nx  = LOAD;
            count_nx  = '0;
            remain_nx = '0;
        end else begin
            case (state)
                IDLE: ;
                LOAD: begin
                    if (cfg_valid) begin
                        hold_nx   = cfg_data;
                        remain_nx = word_bits;
                        state_nx  = SHIFT;
                    end
                end
                SHIFT: begin
                    mem_nx    = {hold[0], mem[CHAIN_LEN-1:1]};
                    hold_nx   = hold >> 1;
                    count_nx  = count + CNT_W'(1);
                    remain_nx = remain - NW'(1);
                    if (remain == NW'(1)) begin
                        state_nx = (count_nx == CHAIN_LEN_C) ? DONE : LOAD;
                    end
                end
                DONE: ;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        truth_table = mem[TT_LEN-1:0];
        out_sel     = mem[CHAIN_LEN-1];
        lut_out     = cfg_done & truth_table[lut_in];
        ble_out     = (cfg_done & out_sel) ? ff_q : lut_out;
        ccff_tail   = mem[0];
    end

endmodule

// File: tb/tb_ble6_lut6_cfg.sv
// Randomized self-checking bench for ble6_lut6_cfg against an index-based chain model.
module tb_ble6_lut6_cfg;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       cfg_done;
    logic [5:0] lut_in;
    logic       lut_out;
    logic       ff_q;
    logic       ble_out;
    logic       ccff_tail;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] words[9];
    int         stalls[9];
    bit         ref_chain[65];

    ble6_lut6_cfg #(.LUT_K(6), .CFG_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .lut_in    (lut_in),
        .lut_out   (lut_out),
        .ff_q      (ff_q),
        .ble_out   (ble_out),
        .ccff_tail (ccff_tail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit j of word k lands at chain index k*8+j; anything past index 64 is discarded.
    task automatic build_ref();
        for (int i = 0; i < 65; i++) ref_chain[i] = 1'b0;
        for (int k = 0; k < 9; k++)
            for (int j = 0; j < 8; j++)
                if (k * 8 + j < 65) ref_chain[k * 8 + j] = words[k][j];
    endtask

    function automatic int expected_done_cycle();
        int s = 75;
        for (int k = 0; k < 9; k++) s += stalls[k];
        return s;
    endfunction

    task automatic run_load(input int abort_word, output int done_cyc);
        int k = 0;
        int st = 0;
        int cyc = 0;
        int acc_cyc = -100;
        done_cyc = -1;
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        step();
        cfg_start = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            if (cfg_done) begin
                done_cyc = cyc;
                break;
            end
            if (cfg_ready && k < 9) begin
                if (st < stalls[k]) begin
                    cfg_valid = 1'b0;
                    cfg_data  = 8'($urandom);
                    st++;
                end else begin
                    cfg_valid = 1'b1;
                    cfg_data  = words[k];
                    acc_cyc   = cyc;
                    k++;
                    st = 0;
                end
            end else begin
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_data  = 8'($urandom);
            end
            step();
            cyc++;
            if (abort_word >= 0 && k == abort_word + 1 && cyc == acc_cyc + 3) begin
                check("abort_done", {31'd0, cfg_done}, 32'd0);
                check("abort_busy", {31'd0, cfg_ready}, 32'd0);
                cfg_valid = 1'b1;
                cfg_data  = 8'($urandom);
                cfg_start = 1'b1;
                step();
                cfg_start = 1'b0;
                cfg_valid = 1'b0;
                check("restart_ready", {31'd0, cfg_ready}, 32'd1);
                check("restart_done", {31'd0, cfg_done}, 32'd0);
                return;
            end
        end
        cfg_valid = 1'b0;
        if (done_cyc < 0) $display("FAIL load_timeout: got no cfg_done expected cfg_done within 400 cycles");
    endtask

    task automatic check_lut(input string tag);
        check({tag, "_done"}, {31'd0, cfg_done}, 32'd1);
        check({tag, "_ready"}, {31'd0, cfg_ready}, 32'd0);
        check({tag, "_tail"}, {31'd0, ccff_tail}, {31'd0, ref_chain[0]});
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            lut_in = 6'(i);
            ff_q   = 1'($urandom);
            #1;
            check({tag, "_lut"}, {31'd0, lut_out}, {31'd0, ref_chain[i]});
            check({tag, "_ble"}, {31'd0, ble_out},
                  {31'd0, (ref_chain[64] ? ff_q : ref_chain[i])});
        end
        step();
    endtask

    task automatic full_load(input string tag);
        int dc;
        build_ref();
        run_load(-1, dc);
        check({tag, "_done_cycle"}, dc, expected_done_cycle());
        check_lut(tag);
    endtask

    initial begin
        int dc;
        reset     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        lut_in    = '0;
        ff_q      = 1'b0;
        repeat (3) step();
        check("rst_ready", {31'd0, cfg_ready}, 32'd0);
        check("rst_done", {31'd0, cfg_done}, 32'd0);
        check("rst_lut", {31'd0, lut_out}, 32'd0);
        check("rst_ble", {31'd0, ble_out}, 32'd0);
        check("rst_tail", {31'd0, ccff_tail}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // AND2 pattern, valid held high
        for (int k = 0; k < 8; k++) words[k] = 8'h88;
        words[8] = 8'h00;
        for (int k = 0; k < 9; k++) stalls[k] = 0;
        full_load("and2");
        @(negedge clk);
        lut_in = 6'd3; #1; check("and2_in3", {31'd0, lut_out}, 32'd1);
        lut_in = 6'd2; #1; check("and2_in2", {31'd0, lut_out}, 32'd0);
        lut_in = 6'd63; #1; check("and2_in63", {31'd0, lut_out}, 32'd1);
        step();

        // Same load with three idle cycles before every word
        for (int k = 0; k < 9; k++) stalls[k] = 3;
        full_load("stall");

        // Output select with an all-zero table
        for (int k = 0; k < 8; k++) words[k] = 8'h00;
        words[8] = 8'h01;
        for (int k = 0; k < 9; k++) stalls[k] = 0;
        full_load("osel");
        @(negedge clk);
        lut_in = 6'($urandom);
        ff_q = 1'b0; #1; check("osel_ff0", {31'd0, ble_out}, 32'd0);
        ff_q = 1'b1; #1; check("osel_ff1", {31'd0, ble_out}, 32'd1);
        check("osel_lut", {31'd0, lut_out}, 32'd0);
        step();

        // Restart during word 3's shift, then a complete AND2 reload
        for (int k = 0; k < 8; k++) words[k] = 8'h88;
        words[8] = 8'h00;
        run_load(3, dc);
        full_load("restart");

        // Surplus bits of the last word are dropped
        for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
        words[8] = 8'hFF;
        full_load("surplus");
        check("surplus_tail_w0", {31'd0, ccff_tail}, {31'd0, words[0][0]});
        for (int c = 0; c < 5; c++) begin
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data  = 8'($urandom);
            step();
        end
        cfg_valid = 1'b0;
        check("surplus_tail_hold", {31'd0, ccff_tail}, {31'd0, words[0][0]});
        check_lut("surplus_hold");

        // Random tables with random stalls
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 9; k++) begin
                words[k]  = 8'($urandom);
                stalls[k] = $urandom_range(0, 4);
            end
            full_load("rand");
        end

        // Asynchronous reset in the middle of a load
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'($urandom);
            step();
        end
        reset = 1'b0;
        #1;
        check("arst_ready", {31'd0, cfg_ready}, 32'd0);
        check("arst_done", {31'd0, cfg_done}, 32'd0);
        check("arst_lut", {31'd0, lut_out}, 32'd0);
        check("arst_ble", {31'd0, ble_out}, 32'd0);
        check("arst_tail", {31'd0, ccff_tail}, 32'd0);
        cfg_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) step();
        check("post_rst_ready", {31'd0, cfg_ready}, 32'd0);
        check("post_rst_done", {31'd0, cfg_done}, 32'd0);
        check("post_rst_tail", {31'd0, ccff_tail}, 32'd0);
        check("post_rst_lut", {31'd0, lut_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
